// File: rtl/seq_divider_pkg.sv
`default_nettype none
// ============================================================================
// Module   : seq_divider_pkg
// Purpose  : Shared definitions for the sequential restoring divider:
//            FSM state encodings and the step-counter width helper.
// Ports    : none (package)
// Options  : none here; the top honours SIGNED_DIV_EN.
// Revision : 1.0 - initial release
// ============================================================================
package seq_divider_pkg;

    // Controller states; encodings are fixed so that waveforms and any
    // external state probes stay stable across builds.
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        ITER = 2'b01,
        DONE = 2'b10
    } state_t;

    // Default geometry and the matching step-counter width.
    localparam int DVD_W_DEF = 8;
    localparam int DVS_W_DEF = 7;
    localparam int CNT_W_DEF = $clog2(DVD_W_DEF);

    // Counter width for a given dividend width: the counter runs from
    // DVD_W-1 down to 0, so $clog2(DVD_W) bits always suffice.
    function automatic int cnt_width(input int dvd_w);
        return (dvd_w > 1) ? $clog2(dvd_w) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/seq_divider_div_step.sv
`default_nettype none
// ============================================================================
// Module   : div_step
// Purpose  : One combinational restoring-division step. Shifts {P,Q} left by
//            one, trial-subtracts the divisor from the shifted partial
//            remainder and keeps or restores it depending on the trial sign.
// Ports    : p_i          partial remainder, DVS_W+1 bits
//            q_i          quotient/dividend shift register, DVD_W bits
//            divisor_i    divisor magnitude, DVS_W bits
//            p_o          next partial remainder
//            q_shift_o    upper DVD_W-1 bits of next Q (Q shifted left)
//            trial_neg_o  trial-subtract sign; next Q[0] is its inverse
// Revision : 1.0 - initial release
// ============================================================================
module div_step #(
    parameter int DVD_W = 8,
    parameter int DVS_W = 7
) (
    input  logic [DVS_W:0]   p_i,
    input  logic [DVD_W-1:0] q_i,
    input  logic [DVS_W-1:0] divisor_i,
    output logic [DVS_W:0]   p_o,
    output logic [DVD_W-2:0] q_shift_o,
    output logic             trial_neg_o
);

    logic [DVS_W+1:0] w_p_shift;
    logic [DVS_W+1:0] w_trial;

    // The shifted partial remainder is kept at DVS_W+2 bits so that the
    // subtraction result carries its own sign bit.
    assign w_p_shift   = {p_i, q_i[DVD_W-1]};
    assign w_trial     = w_p_shift - {2'b00, divisor_i};
    assign trial_neg_o = w_trial[DVS_W+1];

    // P stays below the divisor, so the dropped top bit is always zero.
    assign p_o       = trial_neg_o ? w_p_shift[DVS_W:0] : w_trial[DVS_W:0];
    assign q_shift_o = q_i[DVD_W-2:0];

endmodule
`default_nettype wire

// File: rtl/seq_divider.sv
`default_nettype none
// ============================================================================
// Module   : seq_divider
// Purpose  : Sequential restoring divider with built-in controller. One
//            shift/trial-subtract step per clock; registered quotient,
//            remainder and divide-by-zero flag with a one-cycle done pulse.
// Ports    : clk          rising-edge clock
//            reset        synchronous active-high reset
//            start        request, sampled only in IDLE
//            is_signed    two's-complement operands (SIGNED_DIV_EN only)
//            dividend     DVD_W-bit dividend, latched on accepted start
//            divisor      DVS_W-bit divisor, latched on accepted start
//            busy         high in ITER and DONE
//            done         one-cycle completion pulse
//            quotient     registered quotient
//            remainder    registered remainder
//            div_by_zero  registered divide-by-zero flag
// Options  : define SIGNED_DIV_EN to add the is_signed port and signed mode.
// Revision : 1.0 - initial release
// ============================================================================
module seq_divider
    import seq_divider_pkg::*;
#(
    parameter int DVD_W = 8,
    parameter int DVS_W = 7
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
`ifdef SIGNED_DIV_EN
    input  logic             is_signed,
`endif
    input  logic [DVD_W-1:0] dividend,
    input  logic [DVS_W-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [DVD_W-1:0] quotient,
    output logic [DVS_W-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CNT_W = cnt_width(DVD_W);

    state_t           state_q;
    logic [DVS_W:0]   p_q;
    logic [DVD_W-1:0] q_q;
    logic [DVS_W-1:0] dvs_q;
    logic [CNT_W-1:0] cnt_q;

    // Operand magnitudes presented to the iteration datapath.
    logic [DVD_W-1:0] dvd_mag;
    logic [DVS_W-1:0] dvs_mag;

    // Step outputs and the final (sign-corrected) results.
    logic [DVS_W:0]   p_d;
    logic [DVD_W-2:0] q_shift;
    logic             trial_neg;
    logic [DVD_W-1:0] q_d;
    logic [DVD_W-1:0] quo_res;
    logic [DVS_W-1:0] rem_res;

`ifdef SIGNED_DIV_EN
    logic neg_quo_q;
    logic neg_rem_q;
    logic dvd_neg;
    logic dvs_neg;

    always_comb begin
        dvd_neg = is_signed & dividend[DVD_W-1];
        dvs_neg = is_signed & divisor[DVS_W-1];
        // Negating the most-negative value yields itself, which read as
        // unsigned is exactly its magnitude, so no extra bit is needed.
        dvd_mag = dvd_neg ? -dividend : dividend;
        dvs_mag = dvs_neg ? -divisor  : divisor;
    end
`else
    assign dvd_mag = dividend;
    assign dvs_mag = divisor;
`endif

    div_step #(
        .DVD_W (DVD_W),
        .DVS_W (DVS_W)
    ) u_div_step (
        .p_i         (p_q),
        .q_i         (q_q),
        .divisor_i   (dvs_q),
        .p_o         (p_d),
        .q_shift_o   (q_shift),
        .trial_neg_o (trial_neg)
    );

    // New quotient bit is set when the trial subtraction did not go negative.
    assign q_d = {q_shift, ~trial_neg};

`ifdef SIGNED_DIV_EN
    // Quotient negated on differing signs; remainder follows the dividend.
    // The most-negative / -1 case wraps naturally to 1 followed by zeros.
    always_comb begin
        quo_res = neg_quo_q ? -q_d : q_d;
        rem_res = neg_rem_q ? -p_d[DVS_W-1:0] : p_d[DVS_W-1:0];
    end
`else
    assign quo_res = q_d;
    assign rem_res = p_d[DVS_W-1:0];
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
            p_q         <= '0;
            q_q         <= '0;
            dvs_q       <= '0;
            cnt_q       <= '0;
`ifdef SIGNED_DIV_EN
            neg_quo_q   <= 1'b0;
            neg_rem_q   <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        busy <= 1'b1;
                        if (divisor == '0) begin
                            // Divide by zero skips iteration entirely.
                            state_q     <= DONE;
                            done        <= 1'b1;
                            quotient    <= '1;
                            remainder   <= '0;
                            div_by_zero <= 1'b1;
                        end else begin
                            state_q <= ITER;
                            p_q     <= '0;
                            q_q     <= dvd_mag;
                            dvs_q   <= dvs_mag;
                            cnt_q   <= CNT_W'(DVD_W - 1);
`ifdef SIGNED_DIV_EN
                            neg_quo_q <= dvd_neg ^ dvs_neg;
                            neg_rem_q <= dvd_neg;
`endif
                        end
                    end
                end
                ITER: begin
                    p_q   <= p_d;
                    q_q   <= q_d;
                    cnt_q <= cnt_q - CNT_W'(1);
                    if (cnt_q == '0) begin
                        // Results are captured straight from the last step.
                        state_q     <= DONE;
                        done        <= 1'b1;
                        quotient    <= quo_res;
                        remainder   <= rem_res;
                        div_by_zero <= 1'b0;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    busy    <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
